uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver, the next generation of the team's fixed-rate receiver. Adds a runtime baud divisor, configurable oversample ratio, data width, parity mode and stop-bit count. Adds 3-sample majority voting, parity, framing and break error flags, and a valid/ready output holding register with overrun detection. Sits between the RXD pad synchroniser-free input and any byte consumer, for example a FIFO or a register bridge.

Parameters:
OVERSAMPLE, 16, samples per bit; even, 8..32
DATA_WIDTH, 8, data bits per frame; 5..9
PARITY, "NONE", "NONE" / "ODD" / "EVEN" / "MARK" / "SPACE"
STOP_BITS, 1, 1 or 2
DIV_WIDTH, 16, width of baud_div

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-high
baud_div  in  DIV_WIDTH  oversample tick period minus 1 (tick every baud_div+1 clk); must be >=1
rxd  in  1  serial input, asynchronous to clk
rx_data  out  DATA_WIDTH  received word, LSB = first data bit
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accept; transfer when rx_valid & rx_ready
rx_perr  out  1  parity error for the word in rx_data (0 when PARITY="NONE")
rx_ferr  out  1  framing error (any stop-bit sample 0) for the word in rx_data
rx_break  out  1  break frame (all data, parity and stop samples 0) for the word in rx_data
rx_overrun  out  1  one-cycle pulse: completed frame dropped because holding register full
rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; rxd sync flops preset to 1 (line idle); counters 0.
- rxd passes through a 2-flop synchroniser, giving rxd_s. A falling edge is rxd_s==0 with the previous rxd_s==1.
- Tick generator: counter 0..baud_div. It pulses tick when equal to baud_div, then wraps to 0. It is held at 0 in IDLE. baud_div is captured into a shadow register on start edge detection; changes mid-frame have no effect.
- Sample index s counts 0..OVERSAMPLE-1 on tick and wraps at each bit boundary. The start edge sets s=0.
- Bit decision uses a majority of the samples at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is made on the tick at s=OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PAR, STOP, BRKWAIT.
  - IDLE: on falling edge -> START.
  - START: on the decision, bit 1 means a false start -> IDLE with no output; bit 0 -> DATA.
  - DATA: on each decision, shift the bit in (LSB first). After DATA_WIDTH decisions -> PAR if PARITY!="NONE", else STOP.
  - PAR: on the decision, compute perr. EVEN: XOR(data,p)!=0. ODD: XOR(data,p)!=1. MARK: p!=1. SPACE: p!=0. Then -> STOP.
  - STOP: one decision per stop bit. ferr = OR of (bit==0). On the final stop decision the frame completes. If break -> BRKWAIT, else -> IDLE. No wait for end of stop bit, which allows resync to back-to-back frames.
  - BRKWAIT: stay until rxd_s==1 -> IDLE.
- Frame completion (clock cycle of the final stop decision), registered on the next clk edge:
  - If rx_valid==0, or rx_valid & rx_ready in that same cycle: load rx_data/rx_perr/rx_ferr/rx_break and set rx_valid=1.
  - Otherwise keep the old word, drop the new frame and pulse rx_overrun for 1 cycle.
- Handshake: rx_valid stays high, and rx_data plus all flags stay stable, until rx_valid & rx_ready. rx_valid then drops the next cycle unless a simultaneous load occurs.
- Latency: rx_valid rises exactly 1 clk after the tick carrying the final stop decision.
- rx_busy = (state != IDLE), registered with state.
- arst asserted mid-frame: immediate return to reset values and the partial frame is discarded. After arst deasserts, a line already low does not start a frame until a falling edge is seen.

Decomposition:
- Shared package uart_pkg holds:
  - the parity-mode encodings;
  - the FSM state enum (shared with the companion transmitter);
  - the majority-of-3 function;
  - the parameter-legality checks (OVERSAMPLE even, DATA_WIDTH range).
- One sub-module, uart_baud_tick: baud_div shadow register plus tick counter with enable. It is reusable by the transmitter.

Test Plan:
- Common setup: baud_div=26, OVERSAMPLE=16, so 1 bit = 432 clk (50 MHz, 115200 baud).
- Basic receive, 8N1, 0xA5 sent, rx_ready=1 -> rx_valid pulses 1 cycle, rx_data=0xA5, all flags 0, exactly 1 clk after the stop-bit decision tick.
- Even parity: 0x37 sent with correct parity 1 -> perr=0. Resend with parity 0 -> rx_data=0x37, rx_perr=1. Repeat in MARK mode with p=0 -> perr=1.
- Glitch and false start: 3-tick (81 clk) low pulse on idle line -> no rx_valid, FSM back in IDLE. A single inverted sample at s=8 of data bit 3 in 0x00 -> majority holds, rx_data=0x00.
- Framing and break, 2 stop bits: 0x5A with the second stop bit 0 -> rx_ferr=1. Line held low for 12 bits -> rx_data=0, rx_break=1, rx_ferr=1. No further frame until the line returns high, then 0x11 is received cleanly.
- Overrun and handshake: rx_ready=0, frames 0x01 then 0x02 sent back-to-back -> rx_data stays 0x01 and rx_overrun pulses once at the second completion. Raising rx_ready for 1 cycle -> rx_valid falls.
- Reset mid-frame and divisor change: arst pulsed during data bit 4 of 0xFF -> outputs 0, no rx_valid. baud_div changed to 13 mid-frame -> that frame is still decoded at 27-clk ticks, and the next frame is decoded at 14-clk ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM states, majority vote and
// parameter legality checks used by the receiver and its companion transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE
   } par_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRKWAIT
   } uart_state_e;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   function automatic par_mode_e par_mode(input string s);
      if (s == "ODD")   return PAR_ODD;
      if (s == "EVEN")  return PAR_EVEN;
      if (s == "MARK")  return PAR_MARK;
      if (s == "SPACE") return PAR_SPACE;
      return PAR_NONE;
   endfunction

   // acc is the XOR of the received data bits, p the received parity bit
   function automatic logic par_err(input par_mode_e m, input logic acc, input logic p);
      case (m)
         PAR_EVEN:  return acc ^ p;
         PAR_ODD:   return ~(acc ^ p);
         PAR_MARK:  return ~p;
         PAR_SPACE: return p;
         default:   return 1'b0;
      endcase
   endfunction

   function automatic bit params_ok(input int os, input int dw, input int sb);
      return (os % 2 == 0) && (os >= 8) && (os <= 32) &&
             (dw >= 5) && (dw <= 9) && (sb >= 1) && (sb <= 2);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divisor shadowed on load, counter held at 0
// while disabled, tick when the counter reaches the shadowed divisor.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 en_i,
   input  logic                 load_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 tick_o
);

   logic [DIV_WIDTH-1:0] div_q, cnt_q, cnt_d;

   assign tick_o = en_i & (cnt_q == div_q);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!en_i || tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (load_i) div_q <= div_i;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop sync, 3-sample majority bit decisions,
// parity/framing/break flags and a valid/ready holding register with overrun.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int    OVERSAMPLE = 16,
   parameter int    DATA_WIDTH = 8,
   parameter string PARITY     = "NONE",
   parameter int    STOP_BITS  = 1,
   parameter int    DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [DIV_WIDTH-1:0]  baud_div,
   input  logic                  rxd,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_perr,
   output logic                  rx_ferr,
   output logic                  rx_break,
   output logic                  rx_overrun,
   output logic                  rx_busy
);

   localparam par_mode_e     PMODE   = par_mode(PARITY);
   localparam bit            HAS_PAR = (PMODE != PAR_NONE);
   localparam int            SW      = $clog2(OVERSAMPLE);
   localparam int            CW      = $clog2(DATA_WIDTH);
   localparam logic [SW-1:0] S_LO    = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_HI    = SW'(OVERSAMPLE / 2 + 1);

   if (!params_ok(OVERSAMPLE, DATA_WIDTH, STOP_BITS)) begin : g_bad_params
      $error("uart_rx_os: illegal OVERSAMPLE/DATA_WIDTH/STOP_BITS");
   end

   uart_state_e           state_q, state_d;
   logic                  rxd_meta_q, rxd_s_q, rxd_prev_q;
   logic [1:0]            arm_q;
   logic [SW-1:0]         s_q, s_next;
   logic [1:0]            smp_q;
   logic [CW-1:0]         bcnt_q;
   logic [DATA_WIDTH-1:0] shift_q, rx_data_q;
   logic                  acc_q, perr_q, ferr_q, zero_q;
   logic                  rx_valid_q, rx_perr_q, rx_ferr_q, rx_break_q, rx_overrun_q, busy_q;
   logic                  fall, tick, decide, bit_v, last_data, last_stop;
   logic                  clr_en, shift_en, par_en, stop_en, frame_done, ferr_now, brk_now, load;

   // Edge detect stays disarmed until the synchroniser holds a real rxd
   // sample, so a line already low out of reset is not taken as a start.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
         arm_q      <= '0;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
         rxd_prev_q <= rxd_s_q & arm_q[1];
         arm_q      <= {arm_q[0], 1'b1};
      end
   end

   assign fall = arm_q[1] & rxd_prev_q & ~rxd_s_q;

   uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
      .clk    (clk),
      .arst   (arst),
      .en_i   ((state_q != ST_IDLE) && (state_q != ST_BRKWAIT)),
      .load_i ((state_q == ST_IDLE) && fall),
      .div_i  (baud_div),
      .tick_o (tick)
   );

   assign s_next    = (s_q == SW'(OVERSAMPLE - 1)) ? '0 : s_q + 1'b1;
   assign decide    = tick & (s_next == S_HI);
   assign bit_v     = maj3({rxd_s_q, smp_q});
   assign last_data = (bcnt_q == CW'(DATA_WIDTH - 1));
   assign last_stop = (bcnt_q == CW'(STOP_BITS - 1));
   assign ferr_now  = ferr_q | ~bit_v;
   assign brk_now   = zero_q & ~bit_v;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (fall) state_d = ST_START;
         ST_START:   if (decide) state_d = bit_v ? ST_IDLE : ST_DATA;
         ST_DATA:    if (decide && last_data) state_d = HAS_PAR ? ST_PAR : ST_STOP;
         ST_PAR:     if (decide) state_d = ST_STOP;
         ST_STOP:    if (decide && last_stop) state_d = brk_now ? ST_BRKWAIT : ST_IDLE;
         ST_BRKWAIT: if (rxd_s_q) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      clr_en     = 1'b0;
      shift_en   = 1'b0;
      par_en     = 1'b0;
      stop_en    = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         ST_START: clr_en   = decide & ~bit_v;
         ST_DATA:  shift_en = decide;
         ST_PAR:   par_en   = decide;
         ST_STOP: begin
            stop_en    = decide;
            frame_done = decide & last_stop;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s_q     <= '0;
         smp_q   <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         acc_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) s_q <= '0;
         else if (tick)          s_q <= s_next;
         if (tick && s_next == S_LO)  smp_q[0] <= rxd_s_q;
         if (tick && s_next == S_MID) smp_q[1] <= rxd_s_q;
         if (state_d != state_q) bcnt_q <= '0;
         else if (decide)        bcnt_q <= bcnt_q + 1'b1;
         if (clr_en) begin
            acc_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            zero_q <= 1'b1;
         end
         if (shift_en) begin
            shift_q <= {bit_v, shift_q[DATA_WIDTH-1:1]};
            acc_q   <= acc_q ^ bit_v;
         end
         if (par_en)  perr_q <= par_err(PMODE, acc_q, bit_v);
         if (stop_en) ferr_q <= ferr_now;
         if (shift_en || par_en || stop_en) zero_q <= zero_q & ~bit_v;
      end
   end

   // A completing frame may replace a word that is being accepted this cycle
   assign load = frame_done & (~rx_valid_q | rx_ready);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_perr_q    <= 1'b0;
         rx_ferr_q    <= 1'b0;
         rx_break_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         busy_q       <= (state_d != ST_IDLE);
         rx_overrun_q <= frame_done & rx_valid_q & ~rx_ready;
         if (load) begin
            rx_data_q  <= shift_q;
            rx_perr_q  <= perr_q;
            rx_ferr_q  <= ferr_now;
            rx_break_q <= brk_now;
            rx_valid_q <= 1'b1;
         end else if (rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_perr    = rx_perr_q;
   assign rx_ferr    = rx_ferr_q;
   assign rx_break   = rx_break_q;
   assign rx_overrun = rx_overrun_q;
   assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E2, 8M1) driven with ideal
// serial frames; expectations come from the frame contents and timing rules.
module tb_uart_rx_os;

   localparam int OS = 16;

   logic            clk      = 1'b0;
   logic            arst     = 1'b1;
   logic            rx_ready = 1'b1;
   logic [15:0]     baud_div = 16'd26;
   logic [2:0]      rxd      = 3'b111;
   logic [2:0][7:0] dat;
   logic [2:0]      vld, perr, ferr, brk, ovr, busy;

   int         errors = 0;
   int         checks = 0;
   int         rise_n, ovr_n;
   logic       prev_v = 1'b0;
   logic [7:0] cap_d;
   logic       cap_p, cap_f, cap_b;

   always #5 clk = ~clk;

   uart_rx_os #(.OVERSAMPLE(16), .DATA_WIDTH(8), .PARITY("NONE"), .STOP_BITS(1), .DIV_WIDTH(16)) u_a (
      .clk(clk), .arst(arst), .baud_div(baud_div), .rxd(rxd[0]), .rx_data(dat[0]), .rx_valid(vld[0]),
      .rx_ready(rx_ready), .rx_perr(perr[0]), .rx_ferr(ferr[0]), .rx_break(brk[0]),
      .rx_overrun(ovr[0]), .rx_busy(busy[0]));

   uart_rx_os #(.OVERSAMPLE(16), .DATA_WIDTH(8), .PARITY("EVEN"), .STOP_BITS(2), .DIV_WIDTH(16)) u_b (
      .clk(clk), .arst(arst), .baud_div(baud_div), .rxd(rxd[1]), .rx_data(dat[1]), .rx_valid(vld[1]),
      .rx_ready(rx_ready), .rx_perr(perr[1]), .rx_ferr(ferr[1]), .rx_break(brk[1]),
      .rx_overrun(ovr[1]), .rx_busy(busy[1]));

   uart_rx_os #(.OVERSAMPLE(16), .DATA_WIDTH(8), .PARITY("MARK"), .STOP_BITS(1), .DIV_WIDTH(16)) u_c (
      .clk(clk), .arst(arst), .baud_div(baud_div), .rxd(rxd[2]), .rx_data(dat[2]), .rx_valid(vld[2]),
      .rx_ready(rx_ready), .rx_perr(perr[2]), .rx_ferr(ferr[2]), .rx_break(brk[2]),
      .rx_overrun(ovr[2]), .rx_busy(busy[2]));

   function automatic int nstop(input int inst);
      return (inst == 1) ? 2 : 1;
   endfunction

   function automatic bit haspar(input int inst);
      return inst != 0;
   endfunction

   // Line levels per bit period: start, data LSB first, parity, stop bits
   function automatic logic [15:0] frame_bits(input int inst, input logic [7:0] d, input logic p,
                                              input logic [1:0] st);
      logic [15:0] b;
      int k;
      b = '1;
      b[0] = 1'b0;
      k = 1;
      for (int i = 0; i < 8; i++) begin b[k] = d[i]; k++; end
      if (haspar(inst)) begin b[k] = p; k++; end
      for (int i = 0; i < nstop(inst); i++) begin b[k] = st[i]; k++; end
      return b;
   endfunction

   function automatic logic exp_perr(input int inst, input logic [7:0] d, input logic p);
      if (inst == 1) return ((($countones(d) + int'(p)) % 2) != 0);
      if (inst == 2) return (p != 1'b1);
      return 1'b0;
   endfunction

   function automatic logic exp_ferr(input int inst, input logic [1:0] st);
      return (nstop(inst) == 1) ? !st[0] : (st != 2'b11);
   endfunction

   function automatic logic exp_brk(input int inst, input logic [7:0] d, input logic p, input logic [1:0] st);
      return (d == 8'h00) && (!haspar(inst) || !p) && ((nstop(inst) == 1) ? !st[0] : (st == 2'b00));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives the line for len clocks; records the first rx_valid rise and overrun pulses
   task automatic drive(input int inst, input logic [15:0] bits, input int len, input int bp,
                        input int glitch_c, input int chg_at, input logic [15:0] chg_val);
      logic g;
      int idx;
      rise_n = -1;
      ovr_n  = 0;
      prev_v = vld[inst];
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         if (vld[inst] && !prev_v && rise_n < 0) begin
            rise_n = n;
            cap_d  = dat[inst];
            cap_p  = perr[inst];
            cap_f  = ferr[inst];
            cap_b  = brk[inst];
         end
         prev_v = vld[inst];
         if (ovr[inst]) ovr_n++;
         if (n == chg_at) baud_div = chg_val;
         idx = n / bp;
         g = (glitch_c >= 0) && (n >= glitch_c - 8) && (n <= glitch_c + 8);
         rxd[inst] = ((idx > 15) ? 1'b1 : bits[idx]) ^ g;
      end
   endtask

   task automatic send_chk(input string tag, input int inst, input logic [7:0] d, input logic p,
                           input logic [1:0] st, input int glitch_c, input int chg_at,
                           input logic [15:0] chg_val);
      int bp, nb, lat;
      bp  = OS * (int'(baud_div) + 1);
      nb  = 9 + (haspar(inst) ? 1 : 0) + nstop(inst);
      lat = 3 + ((nb - 1) * OS + OS / 2 + 1) * (int'(baud_div) + 1);
      drive(inst, frame_bits(inst, d, p, st), nb * bp, bp, glitch_c, chg_at, chg_val);
      chk({tag, "_lat"}, rise_n, lat);
      chk({tag, "_data"}, cap_d, d);
      chk({tag, "_perr"}, cap_p, exp_perr(inst, d, p));
      chk({tag, "_ferr"}, cap_f, exp_ferr(inst, st));
      chk({tag, "_brk"}, cap_b, exp_brk(inst, d, p, st));
   endtask

   initial begin
      int inst;
      logic [7:0] d;
      logic p;
      logic [1:0] st;

      repeat (3) @(negedge clk);
      chk("rst_valid", vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", dat[0], 0);
      chk("rst_ovr", ovr, 0);
      arst = 1'b0;
      drive(0, 16'hFFFF, 20, 1, -1, -1, 16'd0);

      send_chk("basic", 0, 8'hA5, 1'b0, 2'b11, -1, -1, 16'd0);
      chk("basic_pulse", vld[0], 0);

      send_chk("even_ok", 1, 8'h37, 1'b1, 2'b11, -1, -1, 16'd0);
      send_chk("even_bad", 1, 8'h37, 1'b0, 2'b11, -1, -1, 16'd0);
      send_chk("mark_bad", 2, 8'h37, 1'b0, 2'b11, -1, -1, 16'd0);
      send_chk("mark_ok", 2, 8'h37, 1'b1, 2'b11, -1, -1, 16'd0);

      drive(0, 16'hFFFE, 700, 81, -1, -1, 16'd0);
      chk("fstart_rise", rise_n, -1);
      chk("fstart_busy", busy[0], 0);
      send_chk("glitch", 0, 8'h00, 1'b0, 2'b11, 4 * 432 + 216, -1, 16'd0);

      send_chk("ferr", 1, 8'h5A, 1'b0, 2'b01, -1, -1, 16'd0);
      drive(1, 16'hFFFF, 100, 1, -1, -1, 16'd0);
      send_chk("break", 1, 8'h00, 1'b0, 2'b00, -1, -1, 16'd0);
      drive(1, 16'h0000, 3 * 432, 432, -1, -1, 16'd0);
      chk("brkwait_rise", rise_n, -1);
      chk("brkwait_busy", busy[1], 1);
      drive(1, 16'hFFFF, 100, 1, -1, -1, 16'd0);
      chk("brk_release_busy", busy[1], 0);
      send_chk("after_brk", 1, 8'h11, 1'b0, 2'b11, -1, -1, 16'd0);

      rx_ready = 1'b0;
      send_chk("ovr_first", 0, 8'h01, 1'b0, 2'b11, -1, -1, 16'd0);
      drive(0, frame_bits(0, 8'h02, 1'b0, 2'b11), 10 * 432, 432, -1, -1, 16'd0);
      chk("ovr_pulses", ovr_n, 1);
      chk("ovr_hold_data", dat[0], 8'h01);
      chk("ovr_hold_valid", vld[0], 1);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk("hs_drop", vld[0], 0);
      rx_ready = 1'b1;

      drive(0, frame_bits(0, 8'hFF, 1'b0, 2'b11), 5 * 432 + 216, 432, -1, -1, 16'd0);
      chk("mid_busy", busy[0], 1);
      arst = 1'b1;
      rxd[0] = 1'b0;
      @(negedge clk);
      chk("arst_busy", busy[0], 0);
      chk("arst_valid", vld[0], 0);
      chk("arst_data", dat[0], 0);
      arst = 1'b0;
      drive(0, 16'h0000, 2 * 432, 432, -1, -1, 16'd0);
      chk("low_after_rst_rise", rise_n, -1);
      chk("low_after_rst_busy", busy[0], 0);
      drive(0, 16'hFFFF, 100, 1, -1, -1, 16'd0);

      send_chk("divchg", 0, 8'hC3, 1'b0, 2'b11, -1, 2000, 16'd13);
      send_chk("div13", 0, 8'h3C, 1'b0, 2'b11, -1, -1, 16'd0);

      for (int i = 0; i < 5; i++) begin
         inst     = $urandom_range(0, 2);
         d        = 8'($urandom);
         p        = 1'($urandom);
         st       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         baud_div = 16'($urandom_range(3, 13));
         send_chk("rand", inst, d, p, st, -1, -1, 16'd0);
         drive(inst, 16'hFFFF, 60, 1, -1, -1, 16'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
